// File: rtl/color_sensor_stabilizer.sv
// color_sensor_stabilizer: waits out motor settle time, then debounces the selected colour sensor into a stable code
// Ports:
//    clock, reset_n                    clock and asynchronous active-low reset
//    motors_done, sensor_sel           start an observation of the corner (0) or edge (1) sensor
//    corner_raw/_valid, edge_raw/_valid classified sensor samples (6,7 illegal)
//    corner_color_sensor, edge_color_sensor  registered colour outputs
//    color_sensor_stable               one-cycle pulse when the selected output is final
//    read_error                        last observation timed out without a stable run
//    busy                              observation in progress (SETTLE or SAMPLE)
module color_sensor_stabilizer #(
   parameter int SETTLE_CYCLES   = 500000,
   parameter int MATCH_COUNT     = 4,
   parameter int TIMEOUT_SAMPLES = 64,
   parameter int CNT_W           = 20
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       motors_done,
   input  logic       sensor_sel,
   input  logic [2:0] corner_raw,
   input  logic       corner_raw_valid,
   input  logic [2:0] edge_raw,
   input  logic       edge_raw_valid,
   output logic [2:0] corner_color_sensor,
   output logic [2:0] edge_color_sensor,
   output logic       color_sensor_stable,
   output logic       read_error,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
   localparam int SW = $clog2(TIMEOUT_SAMPLES + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
   // a zero settle time skips SETTLE entirely
   localparam state_t START = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
   state_t           state;
   logic             sel_q;
   logic [CNT_W-1:0] settle_cnt;
   logic [SW-1:0]    count;
   logic [3:0]       streak;
   logic [2:0]       last_code;
   logic [2:0]       code;
   logic             take, legal, matched, timed_out;
   logic [3:0]       streak_nx;
   logic [SW-1:0]    count_nx;
   assign code      = sel_q ? edge_raw : corner_raw;
   assign take      = (state == SAMPLE) && (sel_q ? edge_raw_valid : corner_raw_valid);
   assign legal     = code < 3'd6;
   assign streak_nx = !legal ? 4'd0 : (code == last_code ? streak + 4'd1 : 4'd1);
   assign count_nx  = count + 1'b1;
   assign matched   = streak_nx == 4'(MATCH_COUNT);
   assign timed_out = count_nx == SW'(TIMEOUT_SAMPLES);
   assign busy      = (state == SETTLE) || (state == SAMPLE);
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state               <= IDLE;
         sel_q               <= 1'b0;
         settle_cnt          <= '0;
         count               <= '0;
         streak              <= '0;
         last_code           <= '0;
         corner_color_sensor <= '0;
         edge_color_sensor   <= '0;
         color_sensor_stable <= 1'b0;
         read_error          <= 1'b0;
      end else begin
         color_sensor_stable <= 1'b0;
         // a new move starts (or restarts) an observation from any state
         if (motors_done) begin
            state      <= START;
            sel_q      <= sensor_sel;
            settle_cnt <= '0;
            count      <= '0;
            streak     <= '0;
            read_error <= 1'b0;
         end else begin
            case (state)
               SETTLE:
                  if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
                  else settle_cnt <= settle_cnt + 1'b1;
               SAMPLE: begin
                  if (sel_q && corner_raw_valid) corner_color_sensor <= corner_raw;
                  if (!sel_q && edge_raw_valid) edge_color_sensor <= edge_raw;
                  if (take) begin
                     count  <= count_nx;
                     streak <= streak_nx;
                     if (legal) last_code <= code;
                     // a streak completing on the final sample wins over timeout
                     if (matched || timed_out) begin
                        if (sel_q) edge_color_sensor <= code;
                        else corner_color_sensor <= code;
                        read_error          <= !matched;
                        color_sensor_stable <= 1'b1;
                        state               <= DONE;
                     end
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_color_sensor_stabilizer.sv
// tb_color_sensor_stabilizer: directed self-checking bench for color_sensor_stabilizer
module tb_color_sensor_stabilizer;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       motors_done = 1'b0, sensor_sel = 1'b0;
   logic [2:0] corner_raw = '0, edge_raw = '0;
   logic       corner_raw_valid = 1'b0, edge_raw_valid = 1'b0;
   logic [2:0] corner_color_sensor, edge_color_sensor;
   logic       color_sensor_stable, read_error, busy;
   int         checks = 0, errors = 0;
   color_sensor_stabilizer #(
      .SETTLE_CYCLES(8), .MATCH_COUNT(4), .TIMEOUT_SAMPLES(8), .CNT_W(8)
   ) dut (
      .clock(clock), .reset_n(reset_n), .motors_done(motors_done), .sensor_sel(sensor_sel),
      .corner_raw(corner_raw), .corner_raw_valid(corner_raw_valid),
      .edge_raw(edge_raw), .edge_raw_valid(edge_raw_valid),
      .corner_color_sensor(corner_color_sensor), .edge_color_sensor(edge_color_sensor),
      .color_sensor_stable(color_sensor_stable), .read_error(read_error), .busy(busy)
   );
   always #5 clock = ~clock;
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask
   task automatic step(input logic md, input logic sel, input logic cv, input logic [2:0] c,
                       input logic ev, input logic [2:0] e);
      motors_done = md;
      sensor_sel = sel;
      corner_raw_valid = cv;
      corner_raw = c;
      edge_raw_valid = ev;
      edge_raw = e;
      @(posedge clock);
      #1;
      motors_done = 1'b0;
      corner_raw_valid = 1'b0;
      edge_raw_valid = 1'b0;
   endtask
   task automatic blanks(input int n);
      for (int i = 0; i < n; i++) begin
         step(0, 0, 0, 0, 0, 0);
         check("settle_nopulse", color_sensor_stable, 0);
      end
   endtask
   task automatic start(input logic sel);
      step(1, sel, 0, 0, 0, 0);
      check("start_busy", busy, 1);
      blanks(8);
      check("sample_busy", busy, 1);
   endtask
   task automatic corner(input logic [2:0] c);
      step(0, 0, 1, c, 0, 0);
   endtask
   task automatic edge_s(input logic [2:0] e);
      step(0, 0, 0, 0, 1, e);
   endtask
   initial begin
      #12;
      check("rst_corner", corner_color_sensor, 0);
      check("rst_edge", edge_color_sensor, 0);
      check("rst_stable", color_sensor_stable, 0);
      check("rst_err", read_error, 0);
      check("rst_busy", busy, 0);
      #4 reset_n = 1'b1;
      @(posedge clock);
      #1;
      // nominal corner run
      start(0);
      corner(2); corner(2); corner(2);
      check("nom_early", color_sensor_stable, 0);
      corner(2);
      check("nom_stable", color_sensor_stable, 1);
      check("nom_corner", corner_color_sensor, 2);
      check("nom_err", read_error, 0);
      check("nom_busy_done", busy, 0);
      step(0, 0, 0, 0, 0, 0);
      check("nom_pulse_end", color_sensor_stable, 0);
      check("nom_idle_busy", busy, 0);
      // samples during settle are discarded, including on the last settle cycle
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         corner(5);
         check("mask_nopulse", color_sensor_stable, 0);
      end
      corner(5); corner(5); corner(5);
      check("mask_early", color_sensor_stable, 0);
      corner(5);
      check("mask_stable", color_sensor_stable, 1);
      check("mask_corner", corner_color_sensor, 5);
      step(0, 0, 0, 0, 0, 0);
      // illegal code breaks the streak
      start(1);
      edge_s(1); edge_s(1); edge_s(7); edge_s(1); edge_s(1); edge_s(1);
      check("streak_early", color_sensor_stable, 0);
      edge_s(1);
      check("streak_stable", color_sensor_stable, 1);
      check("streak_edge", edge_color_sensor, 1);
      check("streak_corner_hold", corner_color_sensor, 5);
      step(0, 0, 0, 0, 0, 0);
      // changed code restarts the streak; non-selected corner follows its own samples
      start(1);
      edge_s(4);
      step(0, 0, 1, 6, 1, 4);
      check("follow_corner", corner_color_sensor, 6);
      edge_s(4); edge_s(0); edge_s(0); edge_s(0);
      check("change_early", color_sensor_stable, 0);
      edge_s(0);
      check("change_stable", color_sensor_stable, 1);
      check("change_edge", edge_color_sensor, 0);
      check("change_corner", corner_color_sensor, 6);
      step(0, 0, 0, 0, 0, 0);
      // timeout after 8 alternating samples
      start(0);
      corner(1); corner(3); corner(1); corner(3); corner(1); corner(3); corner(1);
      check("to_early", color_sensor_stable, 0);
      check("to_early_err", read_error, 0);
      corner(3);
      check("to_stable", color_sensor_stable, 1);
      check("to_err", read_error, 1);
      check("to_corner", corner_color_sensor, 3);
      step(0, 0, 0, 0, 0, 0);
      check("to_err_hold", read_error, 1);
      // streak completing on the timeout sample is a success
      step(1, 0, 0, 0, 0, 0);
      check("to_err_clear", read_error, 0);
      blanks(8);
      corner(1); corner(3); corner(1); corner(3); corner(2); corner(2); corner(2);
      check("edge_to_early", color_sensor_stable, 0);
      corner(2);
      check("edge_to_stable", color_sensor_stable, 1);
      check("edge_to_err", read_error, 0);
      check("edge_to_corner", corner_color_sensor, 2);
      // motors_done during DONE restarts settle
      step(1, 0, 0, 0, 0, 0);
      check("done_md_pulse", color_sensor_stable, 0);
      check("done_md_busy", busy, 1);
      blanks(8);
      corner(4); corner(4); corner(4);
      // abort on what would have been the completing sample
      step(1, 1, 1, 4, 0, 0);
      check("abort_nopulse", color_sensor_stable, 0);
      check("abort_busy", busy, 1);
      check("abort_corner", corner_color_sensor, 2);
      blanks(8);
      edge_s(5); edge_s(5); edge_s(5);
      check("abort_early", color_sensor_stable, 0);
      edge_s(5);
      check("abort_stable", color_sensor_stable, 1);
      check("abort_edge", edge_color_sensor, 5);
      check("abort_corner_hold", corner_color_sensor, 2);
      step(0, 0, 0, 0, 0, 0);
      // asynchronous reset mid-sample
      start(0);
      corner(1); corner(1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_corner", corner_color_sensor, 0);
      check("arst_edge", edge_color_sensor, 0);
      check("arst_busy", busy, 0);
      check("arst_stable", color_sensor_stable, 0);
      check("arst_err", read_error, 0);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         corner(1);
         check("post_rst_nopulse", color_sensor_stable, 0);
         check("post_rst_busy", busy, 0);
      end
      check("post_rst_corner", corner_color_sensor, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/color_sensor_stabilizer.md
Name: color_sensor_stabilizer

Overview:
Sits directly upstream of the cube-state capture FSM and produces its corner_color_sensor, edge_color_sensor and color_sensor_stable inputs. After each motor move completes, it waits a mechanical settle time. It then samples the selected colour sensor's classified 3-bit code until a run of identical legal codes is seen. It presents the colour and pulses color_sensor_stable; if no stable run appears within a bounded number of samples, it flags read_error.

Parameters:
SETTLE_CYCLES, 500000, clock cycles to ignore sensor data after motors_done (10 ms at 50 MHz); 0 allowed
MATCH_COUNT, 4, consecutive identical legal samples required; range 1..15
TIMEOUT_SAMPLES, 64, max accepted samples per observation before giving up; must be >= MATCH_COUNT
CNT_W, 20, settle counter width; must hold SETTLE_CYCLES

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
motors_done  in  1  one-cycle pulse from motor sequencer: cube has stopped turning
sensor_sel  in  1  0 = corner sensor, 1 = edge sensor; sampled only on the motors_done cycle
corner_raw  in  3  classified corner sensor code (W=0,O=1,G=2,R=3,B=4,Y=5; 6,7 illegal)
corner_raw_valid  in  1  corner_raw is a new sample this cycle
edge_raw  in  3  classified edge sensor code, same encoding
edge_raw_valid  in  1  edge_raw is a new sample this cycle
corner_color_sensor  out  3  registered corner colour
edge_color_sensor  out  3  registered edge colour
color_sensor_stable  out  1  one-cycle pulse: the selected colour output is final
read_error  out  1  the last observation timed out
busy  out  1  high in SETTLE or SAMPLE

Behaviour:
- Reset values (async, reset_n low): state IDLE, all outputs 0, counters 0, sel_q 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: on motors_done, latch sel_q<=sensor_sel, clear read_error, streak, sample count and settle counter. Go to SETTLE; if SETTLE_CYCLES==0, go directly to SAMPLE.
- SETTLE: the settle counter increments every cycle. Move to SAMPLE on the cycle the counter reaches SETTLE_CYCLES-1, so SAMPLE is entered exactly SETTLE_CYCLES cycles after the motors_done cycle. Valid samples received during SETTLE are discarded.
- SAMPLE: only the selected channel's valid strobe counts.
  - Each accepted sample increments the sample count.
  - A legal code equal to last_code increments the streak.
  - A legal code different from last_code sets streak=1 and last_code=code.
  - An illegal code (6/7) sets streak=0.
  - When streak reaches MATCH_COUNT: write last_code to the selected output and go to DONE.
  - Otherwise, if the sample count reaches TIMEOUT_SAMPLES: write the most recent sampled code (possibly illegal) to the selected output, set read_error=1 and go to DONE.
  - A streak completion on the TIMEOUT_SAMPLES-th sample counts as success, with no error.
- Non-selected channel: while in SAMPLE, its output register follows each of its own valid samples. It is never stable-qualified.
- DONE: color_sensor_stable=1 for exactly this one cycle, then IDLE. Latency is 1 cycle from the completing sample's clock edge to the stable pulse.
- Output hold: colour outputs and read_error hold their values until overwritten. read_error clears only on the next motors_done.
- motors_done while in SETTLE or SAMPLE: the cube moved again, so abort the observation. Re-latch sensor_sel, clear counters and streak, restart SETTLE. No stable pulse is issued for the aborted observation.
- motors_done in DONE: the stable pulse is still issued; the FSM then enters SETTLE (not IDLE) with the new sel_q.
- Both valid strobes in one cycle: each channel is handled independently as above.
- busy=1 in SETTLE and SAMPLE, 0 in IDLE and DONE.
- reset_n asserted mid-observation: immediate return to reset values, with no stable pulse.

Test Plan:
- Nominal corner: SETTLE_CYCLES=8, MATCH_COUNT=4, sensor_sel=0, motors_done at cycle 0; corner codes 2,2,2,2 valid every cycle from cycle 9 -> corner_color_sensor=2, stable pulse one cycle after the 4th sample, read_error=0, busy low afterwards.
- Settle masking: corner samples of 5 during cycles 1..8, then 3,3,3,3 -> output 3; the 5s are ignored and no early pulse occurs.
- Streak reset: edge sel, codes 1,1,7,1,1,1,1 -> edge_color_sensor=1 after the 7th sample, not before; codes 4,4,4,0,0,0,0 -> output 0.
- Timeout: TIMEOUT_SAMPLES=8, alternating 1,3,... -> after the 8th sample stable pulses, read_error=1, output=3; next motors_done clears read_error.
- Abort: motors_done again mid-SAMPLE with sel flipped to 1 -> no pulse, SETTLE restarts, the subsequent edge streak drives edge_color_sensor only.
- Async reset: assert reset_n low mid-SAMPLE, between clock edges -> all outputs 0 immediately, state IDLE, no stable pulse after release until a new motors_done.
